// File: rtl/osd_spi_master.sv
// osd_spi_master: byte-wide SPI master for the OSD/userio link (SCK idles high,
// MOSI changes on the falling edge, sampled on the rising edge, MSB first).
// Receive path is built only when OSD_SPI_MASTER_RX_EN is defined.
module osd_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic       start,
  input  logic       cs_en,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       _scs,
  output logic       sck,
  output logic       sdo,
  input  logic       sdi
);
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, DONE} state_t;

  state_t     state;
  logic [6:0] tx_sh;     // bits still to send; bit 7 goes straight to sdo
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic       phase_end;

  assign phase_end = (div_cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state   <= IDLE;
      tx_sh   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      _scs    <= 1'b1;
      sck     <= 1'b1;
      sdo     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            tx_sh   <= tx_data[6:0];
            sdo     <= tx_data[7];
            _scs    <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
            // A held chip select skips the CS setup phase.
            sck     <= _scs;
            state   <= _scs ? SETUP : LOW;
          end else begin
            state <= IDLE;
          end
        end
        SETUP, LOW: begin
          if (phase_end) begin
            div_cnt <= '0;
            sck     <= (state == LOW);
            state   <= (state == LOW) ? HIGH : LOW;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              if (!cs_en) begin
                _scs <= 1'b1;
                sdo  <= 1'b0;
              end
            end else begin
              state <= LOW;
              sck   <= 1'b0;
              sdo   <= tx_sh[6];
              tx_sh <= {tx_sh[5:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OSD_SPI_MASTER_RX_EN
  logic [7:0] rx_sh;

  // MISO is captured on the clk edge that raises sck.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rx_sh   <= '0;
      rx_data <= '0;
    end else begin
      if (state == LOW && phase_end)
        rx_sh <= {rx_sh[6:0], sdi};
      if (state == HIGH && phase_end && bit_cnt == 3'd7)
        rx_data <= rx_sh;
    end
  end
`else
  logic unused_sdi;
  assign unused_sdi = sdi;
  assign rx_data    = 8'h00;
`endif

endmodule

// File: tb/tb_osd_spi_master.sv
// Bench for osd_spi_master: two instances (CLK_DIV=2 and 1), each with a
// behavioural SPI slave; randomized bytes checked against a frame-level model.
module tb_osd_spi_master;
`ifdef OSD_SPI_MASTER_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic _reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance 0: CLK_DIV=2 ----------------
  logic       start0 = 0, cs0 = 0, sdi0 = 0;
  logic [7:0] tx0 = 0, rx0;
  logic       busy0, done0, scs0, sck0, sdo0;

  osd_spi_master #(.CLK_DIV(2)) u0 (
    .clk(clk), ._reset(_reset), .start(start0), .cs_en(cs0), .tx_data(tx0),
    .rx_data(rx0), .busy(busy0), .done(done0), ._scs(scs0), .sck(sck0),
    .sdo(sdo0), .sdi(sdi0)
  );

  // Slave 0: drives MISO on falling sck, samples MOSI on rising sck.
  logic [7:0] miso0 = 0, mosi_sh0 = 0;
  int fall0 = 0, rise0 = 0;
  logic [7:0] mosi_q[$];
  int pos_q[$];
  always @(negedge scs0) begin fall0 = 0; rise0 = 0; end
  always @(negedge sck0) if (!scs0) begin sdi0 = miso0[7 - (fall0 % 8)]; fall0++; end
  always @(posedge sck0) if (!scs0) begin
    mosi_sh0 = {mosi_sh0[6:0], sdo0};
    rise0++;
    if (rise0 % 8 == 0) begin
      mosi_q.push_back(mosi_sh0);
      pos_q.push_back(rise0 / 8 - 1);
    end
  end

  // ---------------- instance 1: CLK_DIV=1 ----------------
  logic       start1 = 0, cs1 = 0, sdi1 = 0;
  logic [7:0] tx1 = 0, rx1;
  logic       busy1, done1, scs1, sck1, sdo1;

  osd_spi_master #(.CLK_DIV(1)) u1 (
    .clk(clk), ._reset(_reset), .start(start1), .cs_en(cs1), .tx_data(tx1),
    .rx_data(rx1), .busy(busy1), .done(done1), ._scs(scs1), .sck(sck1),
    .sdo(sdo1), .sdi(sdi1)
  );

  logic [7:0] miso1 = 0, mosi_sh1 = 0;
  int fall1 = 0;
  longint last1 = 0, per1 = 0;
  always @(negedge scs1) fall1 = 0;
  always @(negedge sck1) if (!scs1) begin sdi1 = miso1[7 - (fall1 % 8)]; fall1++; end
  always @(posedge sck1) if (!scs1) begin
    mosi_sh1 = {mosi_sh1[6:0], sdo1};
    per1  = $time - last1;
    last1 = $time;
  end

  // ---------------- reference model state ----------------
  bit frame_open = 1'b0;   // previous byte kept CS asserted
  int last_pos = 0;

  task automatic wait_done0(output int d);
    d = -1;
    for (int i = 0; i < 200; i++) begin
      if (done0) begin d = cyc; break; end
      @(negedge clk);
    end
    if (d < 0) chk("done0_timeout", 0, 1);
  endtask

  task automatic no_done0(input int ncyc, input string tag);
    int seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done0) seen++;
    end
    chk(tag, seen, 0);
  endtask

  // Runs one byte on u0 starting at the current negedge; ends in the done cycle.
  task automatic byte0(input logic [7:0] tx, input logic cs, input logic [7:0] mi,
                       input bit inject, input string tag);
    int n, d, exp_pos, pos;
    logic [7:0] got;
    exp_pos = frame_open ? last_pos + 1 : 0;
    tx0 = tx; cs0 = cs; miso0 = mi; start0 = 1'b1;
    n = cyc;
    @(negedge clk);
    start0 = 1'b0;
    tx0 = 8'($urandom);
    chk({tag, "_busy"}, busy0, 1);
    chk({tag, "_scs_lo"}, scs0, 0);
    if (inject) begin
      repeat (4) @(negedge clk);
      tx0 = ~tx; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
    end
    wait_done0(d);
    chk({tag, "_lat"}, d - n, frame_open ? 1 + 16 * 2 : 1 + 17 * 2);
    chk({tag, "_rx"}, rx0, RX_EN ? mi : 8'h00);
    chk({tag, "_scs_done"}, scs0, !cs);
    chk({tag, "_busy_done"}, busy0, 0);
    if (mosi_q.size() == 0) chk({tag, "_mosi_missing"}, 0, 1);
    else begin
      got = mosi_q.pop_front();
      pos = pos_q.pop_front();
      chk({tag, "_mosi"}, got, tx);
      chk({tag, "_pos"}, pos, exp_pos);
    end
    if (!cs) chk({tag, "_sdo_idle"}, sdo0, 0);
    last_pos   = exp_pos;
    frame_open = cs;
  endtask

  initial begin
    int n, d, d1, idle;
    bit chain;
    logic cs;

    repeat (3) @(negedge clk);
    chk("rst_scs", scs0, 1);
    chk("rst_sck", sck0, 1);
    chk("rst_sdo", sdo0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_rx", rx0, 0);
    _reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, CS released at the end.
    byte0(8'hA5, 1'b0, 8'h3C, 1'b0, "single");
    repeat (3) @(negedge clk);

    // Two-byte command, back-to-back with start in the done cycle.
    byte0(8'h12, 1'b1, 8'h55, 1'b0, "cmd");
    d1 = cyc;
    byte0(8'h34, 1'b0, 8'hAA, 1'b0, "data");
    chk("b2b_gap", cyc - d1, 33);
    repeat (2) @(negedge clk);

    // Start pulsed mid-byte must be ignored.
    byte0(8'hC3, 1'b0, 8'h0F, 1'b1, "ignore");
    no_done0(50, "ignore_extra_done");

    // Randomized bytes, mixed continuations and idle gaps.
    for (int k = 0; k < 14; k++) begin
      cs = (k == 13) ? 1'b0 : 1'($urandom_range(0, 1));
      byte0(8'($urandom), cs, 8'($urandom), 1'b0, "rand");
      chain = 1'($urandom_range(0, 1));
      if (!chain) begin
        idle = $urandom_range(1, 3);
        repeat (idle) @(negedge clk);
      end
    end
    repeat (2) @(negedge clk);

    // Reset in the middle of bit 3.
    tx0 = 8'h5A; cs0 = 1'b1; miso0 = 8'hF0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (rise0 == 3 && !sck0) begin n = 1; break; end
      @(negedge clk);
    end
    chk("rst_mid_reached", n, 1);
    _reset = 1'b0;
    #1;
    chk("rst_mid_scs", scs0, 1);
    chk("rst_mid_sck", sck0, 1);
    chk("rst_mid_sdo", sdo0, 0);
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_rx", rx0, 0);
    @(negedge clk);
    _reset = 1'b1;
    frame_open = 1'b0;
    cs0 = 1'b0;
    no_done0(40, "rst_mid_no_done");
    chk("rst_mid_no_byte", mosi_q.size(), 0);
    chk("rst_mid_rx_after", rx0, 0);

    // CLK_DIV=1 instance.
    tx1 = 8'hFF; cs1 = 1'b0; miso1 = 8'h81; start1 = 1'b1;
    n = cyc;
    @(negedge clk);
    start1 = 1'b0;
    tx1 = 8'h00;
    d = -1;
    for (int i = 0; i < 100; i++) begin
      if (done1) begin d = cyc; break; end
      @(negedge clk);
    end
    chk("div1_lat", d - n, 18);
    chk("div1_rx", rx1, RX_EN ? 8'h81 : 8'h00);
    chk("div1_mosi", mosi_sh1, 8'hFF);
    chk("div1_sck_period", 32'(per1), 20);
    chk("div1_scs_done", scs1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/osd_spi_master.md
# osd_spi_master

Host-side SPI master that drives the OSD/userio 8-bit SPI slave link. It generates chip select, serial clock and MOSI from a single system clock, and captures MISO one byte per transfer. Protocol details:
- Clock idles high.
- Data changes on the falling SCK edge and is sampled on the rising edge.
- MSB first.

It sits between the control CPU/bridge and the SPI pins of the OSD/userio slave.

## Interface
Parameters:
- CLK_DIV, default 4: length of one SCK half-period in clk cycles. Legal range 1..255.

Ports:
- clk, in, 1: system clock. All logic runs on its rising edge.
- _reset, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle request to transfer tx_data. Accepted only when busy=0.
- cs_en, in, 1: keep _scs asserted after the current byte. Sampled at byte end.
- tx_data, in, 8: byte to send. Captured in the cycle start is accepted.
- rx_data, out, 8: last received byte. Valid from the done cycle and held until the next done.
- busy, out, 1: high while a byte is in flight.
- done, out, 1: one-cycle pulse when a byte completes.
- _scs, out, 1: SPI chip select, active low.
- sck, out, 1: SPI clock. Idles high.
- sdo, out, 1: MOSI.
- sdi, in, 1: MISO.

## Operation
States:
- IDLE: sck=1, busy=0. start with busy=0 captures tx_data into the TX shift register and moves to:
  - SETUP, if _scs=1;
  - LOW, if _scs is already 0 (continuation byte).
  - In both cases sdo=tx_data[7] and _scs=0 from the next cycle.
- SETUP: _scs=0, sck=1 for CLK_DIV cycles, then LOW. Provides CS-to-first-edge setup time.
- LOW: sck=0 for CLK_DIV cycles.
  - On entry for bits 1..7, the TX register shifts left and sdo shows the next bit. Bit 0 (tx[7]) is already on sdo.
  - On the last LOW cycle, sdi is shifted into the RX register LSB. This is the same edge that raises sck.
- HIGH: sck=1 for CLK_DIV cycles.
  - The bit counter increments at the end of the phase.
  - After the 8th HIGH phase, go to DONE; otherwise go back to LOW.
- DONE (single cycle):
  - done=1, rx_data is loaded, busy=0.
  - If cs_en=0, _scs goes to 1 in this cycle and sdo goes to 0.
  - Returns to IDLE. A start seen in this cycle is accepted exactly as in IDLE.

Rules:
- The first byte after _scs falls is the slave's command byte. The host keeps cs_en=1 across all bytes of a command and clears it on the last byte.
- sdo is 0 whenever _scs=1.
- start while busy=1 is ignored; no queueing.
- tx_data changes after acceptance have no effect.
- cs_en changes mid-byte are ignored. Only the value at the end of the 8th HIGH phase matters.
- Bit counter is 3 bits and wraps 7→0 at byte end.
- rx_data is not updated if the byte is aborted by reset.

## Timing
- Reset values: _scs=1, sck=1, sdo=0, busy=0, done=0, rx_data=8'h00, state IDLE, counters 0.
- Reset asserted mid-byte: outputs return to their reset values immediately (asynchronously). The slave sees _scs rise, which aborts its byte.
- start accepted at clk edge N:
  - busy=1 and _scs=0 from edge N+1.
  - First byte: done at edge N+1+17*CLK_DIV (CLK_DIV cycles of SETUP + 8×(LOW+HIGH)).
  - Continuation byte: done at edge N+1+16*CLK_DIV.
- Back-to-back bytes with cs_en=1 and start asserted in the done cycle: next byte's first falling sck occurs 1 cycle after done, with no CS gap.
- SCK frequency is clk/(2*CLK_DIV). Duty cycle is 50%. The slave's clock domain must be at least 3× the SCK rate.

## Configuration
- OSD_SPI_MASTER_RX_EN:
  - Defined: RX shift register and rx_data operate as described.
  - Undefined: receive path removed. sdi is ignored and rx_data is constant 8'h00. TX, CS, done and busy behaviour is unchanged, as are timing and latencies.

## Test plan
- Reset, then CLK_DIV=2, start with tx_data=8'hA5 and cs_en=0, slave model returning 8'h3C:
  - sdo bits sampled at sck rising edges = 1,0,1,0,0,1,0,1.
  - done at N+35.
  - rx_data=8'h3C.
  - _scs=1 in the done cycle.
- Two-byte command, cs_en=1 on the first byte, start in the done cycle, bytes 8'h12 then 8'h34:
  - _scs stays 0 between bytes.
  - Second done 33 cycles after the first.
  - Slave decodes 8'h12 as the command byte and 8'h34 as data.
- start pulsed again 5 cycles into a byte:
  - Ignored.
  - Exactly one done.
  - sdo pattern matches the first tx_data.
- _reset pulled low in the middle of bit 3:
  - _scs=1, sck=1, sdo=0, busy=0 asynchronously.
  - rx_data keeps its prior value (8'h00 after reset).
  - No done.
- CLK_DIV=1, tx_data=8'hFF, slave returns 8'h81:
  - done at N+18.
  - sck period is 2 clk cycles.
  - rx_data=8'h81.
- OSD_SPI_MASTER_RX_EN undefined, slave returns 8'hFF:
  - rx_data=8'h00.
  - done timing identical to the first scenario.
